// File: rtl/vram_write_arbiter.sv
// Write-port arbiter for the 160x120 1-bit VRAM: round-robin between two requesters,
// drops out-of-range writes, optional full clear sweep compiled in by VRAM_ARB_CLEAR_EN.
module vram_write_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int VRAM_SIZE = 19200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_data,
  output logic              b_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_we,
  output logic [7:0]        oor_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_SIZE - 1);

  logic              last_b;
  logic              a_elig;
  logic              b_elig;
  logic              grant_a;
  logic              grant_b;
  logic [ADDR_W-1:0] gnt_addr;
  logic              gnt_data;
  logic              gnt_ok;

`ifdef VRAM_ARB_CLEAR_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  logic [0:0] state;
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign clear_busy         = 1'b0;
`endif

  // A requester still seeing its ack this cycle is not eligible, so held requests alternate.
  always_comb begin
    a_elig   = a_req & ~a_ack;
    b_elig   = b_req & ~b_ack;
    grant_a  = a_elig & (~b_elig | last_b);
    grant_b  = b_elig & (~a_elig | ~last_b);
    gnt_addr = grant_a ? a_addr : b_addr;
    gnt_data = grant_a ? a_data : b_data;
    gnt_ok   = (gnt_addr <= LAST_ADDR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
`ifdef VRAM_ARB_CLEAR_EN
      state      <= ST_IDLE;
      clear_busy <= 1'b0;
`endif
      last_b    <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_data  <= 1'b0;
      oor_count <= '0;
    end else begin
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      ram_we <= 1'b0;
`ifdef VRAM_ARB_CLEAR_EN
      // ram_addr doubles as the sweep counter; it holds the address written this cycle.
      if (state == ST_CLEAR) begin
        if (ram_addr == LAST_ADDR) begin
          state      <= ST_IDLE;
          clear_busy <= 1'b0;
        end else begin
          ram_addr <= ram_addr + ADDR_W'(1);
          ram_we   <= 1'b1;
        end
      end else if (clear_start) begin
        state      <= ST_CLEAR;
        clear_busy <= 1'b1;
        ram_addr   <= '0;
        ram_data   <= 1'b0;
        ram_we     <= 1'b1;
      end else
`endif
      if (grant_a || grant_b) begin
        a_ack  <= grant_a;
        b_ack  <= grant_b;
        last_b <= grant_b;
        if (gnt_ok) begin
          ram_we   <= 1'b1;
          ram_addr <= gnt_addr;
          ram_data <= gnt_data;
        end else if (oor_count != 8'hFF) begin
          oor_count <= oor_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed self-checking bench for vram_write_arbiter; expected RAM writes go through a scoreboard queue.
module tb_vram_write_arbiter;

  localparam int ADDR_W    = 15;
  localparam int VRAM_SIZE = 19200;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear_start = 1'b0;
  logic              clear_busy;
  logic              a_req = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic              a_data = 1'b0;
  logic              a_ack;
  logic              b_req = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic              b_data = 1'b0;
  logic              b_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_we;
  logic [7:0]        oor_count;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t sb[$];

  vram_write_arbiter #(.ADDR_W(ADDR_W), .VRAM_SIZE(VRAM_SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .clear_start(clear_start), .clear_busy(clear_busy),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .oor_count(oor_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] addr, input logic data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic expect_write(input string tag);
    wr_t e;
    chk({tag, "_we"}, 32'(ram_we), 32'd1);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_sb: observed write addr %0d, expected no queued write", tag, ram_addr);
    end else begin
      e = sb.pop_front();
      chk({tag, "_addr"}, 32'(ram_addr), 32'(e.addr));
      chk({tag, "_data"}, 32'(ram_data), 32'(e.data));
    end
  endtask

  initial begin
    int acks;
    int bad;
    logic any_we;

    // reset state
    step();
    step();
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_data", 32'(ram_data), 0);
    chk("rst_oor", 32'(oor_count), 0);
    reset_n = 1'b1;
    step();

    // single requester: ack next cycle, held req re-granted no earlier than N+3
    a_req = 1'b1; a_addr = 15'd5; a_data = 1'b1;
    push(15'd5, 1'b1);
    step();
    chk("single_ack1", 32'(a_ack), 1);
    chk("single_back1", 32'(b_ack), 0);
    expect_write("single_w1");
    push(15'd5, 1'b1);
    step();
    chk("single_ack_gap", 32'(a_ack), 0);
    chk("single_we_gap", 32'(ram_we), 0);
    step();
    chk("single_ack2", 32'(a_ack), 1);
    expect_write("single_w2");
    a_req = 1'b0;
    step();
    chk("single_idle_ack", 32'(a_ack), 0);
    chk("single_idle_we", 32'(ram_we), 0);

    // contention from reset: A wins the first tie, then strict alternation
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    a_req = 1'b1; a_addr = 15'd10; a_data = 1'b1;
    b_req = 1'b1; b_addr = 15'd20; b_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push(15'd10, 1'b1);
      else            push(15'd20, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("cont_a_ack%0d", i), 32'(a_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("cont_b_ack%0d", i), 32'(b_ack), (i % 2 == 1) ? 32'd1 : 32'd0);
      expect_write($sformatf("cont_w%0d", i));
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();
    chk("cont_end_we", 32'(ram_we), 0);

    // last valid address is written
    a_req = 1'b1; a_addr = 15'd19199; a_data = 1'b1;
    push(15'd19199, 1'b1);
    step();
    chk("last_ack", 32'(a_ack), 1);
    expect_write("last_w");
    chk("last_oor", 32'(oor_count), 0);
    a_req = 1'b0;
    step();

    // out of range: acked, not written, counted and saturating
    b_req = 1'b1; b_addr = 15'd19200; b_data = 1'b1;
    step();
    chk("oor_ack", 32'(b_ack), 1);
    chk("oor_we", 32'(ram_we), 0);
    chk("oor_cnt1", 32'(oor_count), 1);
    acks = 0;
    any_we = 1'b0;
    for (int i = 0; i < 299; i++) begin
      step();
      if (ram_we) any_we = 1'b1;
      if (b_ack) acks++;
      step();
      if (ram_we) any_we = 1'b1;
      if (b_ack) acks++;
      if (i == 253) chk("oor_cnt255_reach", 32'(oor_count), 255);
    end
    b_req = 1'b0;
    chk("oor_acks", 32'(acks), 299);
    chk("oor_no_we", 32'(any_we), 0);
    chk("oor_sat", 32'(oor_count), 255);
    step();

`ifdef VRAM_ARB_CLEAR_EN
    // clear wins over a simultaneous request; the request waits for the sweep end
    clear_start = 1'b1;
    a_req = 1'b1; a_addr = 15'd7; a_data = 1'b1;
    for (int k = 0; k < VRAM_SIZE; k++) push(ADDR_W'(k), 1'b0);
    bad = 0;
    for (int k = 0; k < VRAM_SIZE; k++) begin
      step();
      clear_start = (k == 500) ? 1'b1 : 1'b0;
      expect_write($sformatf("clr_w%0d", k));
      if (a_ack !== 1'b0 || clear_busy !== 1'b1) bad++;
    end
    chk("clr_busy_noack", 32'(bad), 0);
    push(15'd7, 1'b1);
    step();
    chk("clr_busy_fall", 32'(clear_busy), 0);
    chk("clr_end_we", 32'(ram_we), 0);
    chk("clr_end_ack", 32'(a_ack), 0);
    step();
    chk("clr_after_ack", 32'(a_ack), 1);
    expect_write("clr_after_w");
    a_req = 1'b0;
    step();

    // reset mid-clear abandons the sweep
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int k = 0; k < 1000; k++) step();
    chk("rclr_addr", 32'(ram_addr), 1000);
    reset_n = 1'b0;
    #1;
    chk("rclr_busy", 32'(clear_busy), 0);
    chk("rclr_we", 32'(ram_we), 0);
    step();
    reset_n = 1'b1;
    any_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ram_we || clear_busy) any_we = 1'b1;
    end
    chk("rclr_no_resume", 32'(any_we), 0);
    chk("rclr_oor", 32'(oor_count), 0);
`else
    // clear disabled: clear_start has no effect
    clear_start = 1'b1;
    a_req = 1'b1; a_addr = 15'd3; a_data = 1'b0;
    push(15'd3, 1'b0);
    step();
    clear_start = 1'b0;
    chk("noclr_busy", 32'(clear_busy), 0);
    chk("noclr_ack", 32'(a_ack), 1);
    expect_write("noclr_w");
    a_req = 1'b0;
    step();
    chk("noclr_busy2", 32'(clear_busy), 0);
    chk("noclr_we2", 32'(ram_we), 0);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
